tmds_encoder_multi: RTL

- Parametrised multi-channel TMDS encoder: successor to the single-channel DVI encoder.
- Encodes NUM_CH lanes in lockstep. Per lane, a mode input selects one of: 8b/10b video, 2-bit control, HDMI video guard band, TERC4 data island, or data-island guard band.
- Sits between the video timing/packet mux and the 10:1 serialisers of the HDMI output path.

---
 rtl/tmds_encoder_multi.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/tmds_encoder_multi.sv
// Multi-lane TMDS encoder: DVI 8b/10b video, control, guard bands and TERC4, with a two-stage pipeline.
// Optional per-lane disparity monitor ports (o_disp_err, o_disp) are enabled by defining TMDS_DISP_MON_EN.
module tmds_encoder_multi #(
    parameter int NUM_CH = 3,
    parameter int CNT_W  = 5
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [2:0]              i_mode,
    input  logic [8*NUM_CH-1:0]     i_data,
    input  logic [2*NUM_CH-1:0]     i_ctrl,
    input  logic [4*NUM_CH-1:0]     i_aux,
`ifdef TMDS_DISP_MON_EN
    output logic [NUM_CH-1:0]       o_disp_err,
    output logic [CNT_W*NUM_CH-1:0] o_disp,
`endif
    output logic [10*NUM_CH-1:0]    o_encoded,
    output logic                    o_valid
);

    typedef enum logic [2:0] {
        MODE_CTRL  = 3'd0,
        MODE_VIDEO = 3'd1,
        MODE_VGB   = 3'd2,
        MODE_TERC4 = 3'd3,
        MODE_DIGB  = 3'd4
    } mode_e;

    localparam logic [9:0]              CTRL_SYM_00 = 10'b1101010100;
    localparam logic signed [CNT_W-1:0] ZERO        = '0;
    localparam logic signed [CNT_W-1:0] TWO         = CNT_W'(2);
    localparam logic signed [CNT_W-1:0] POS_LIM     = CNT_W'(8);
    localparam logic signed [CNT_W-1:0] NEG_LIM     = -POS_LIM;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

    function automatic logic signed [CNT_W-1:0] to_signed(input logic [3:0] v);
        return {{(CNT_W-4){1'b0}}, v};
    endfunction

    // DVI transition minimisation; q[8] = 1 marks the XOR path.
    function automatic logic [8:0] qm_encode(input logic [7:0] d);
        logic [3:0] n1;
        logic       use_xnor;
        logic [8:0] q;
        n1       = popcount8(d);
        use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
        q        = '0;
        q[0]     = d[0];
        for (int i = 1; i < 8; i++) begin
            q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
        end
        q[8] = ~use_xnor;
        return q;
    endfunction

    function automatic logic [9:0] ctrl_sym(input logic [1:0] c);
        case (c)
            2'b00:   return 10'b1101010100;
            2'b01:   return 10'b0010101011;
            2'b10:   return 10'b0101010100;
            default: return 10'b1010101011;
        endcase
    endfunction

    function automatic logic [9:0] terc4_sym(input logic [3:0] a);
        case (a)
            4'd0:    return 10'b1010011100;
            4'd1:    return 10'b1001100011;
            4'd2:    return 10'b1011100100;
            4'd3:    return 10'b1011100010;
            4'd4:    return 10'b0101110001;
            4'd5:    return 10'b0100011110;
            4'd6:    return 10'b0110001110;
            4'd7:    return 10'b0100111100;
            4'd8:    return 10'b1011001100;
            4'd9:    return 10'b0100111001;
            4'd10:   return 10'b0110011100;
            4'd11:   return 10'b1011000110;
            4'd12:   return 10'b1010001110;
            4'd13:   return 10'b1001110001;
            4'd14:   return 10'b0101100011;
            default: return 10'b1011000011;
        endcase
    endfunction

    mode_e mode_p1;
    logic  vld_p1;
    logic  vld_p2;

    // Stage 1: shared mode decode and valid tracking
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mode_p1 <= MODE_CTRL;
            vld_p1  <= 1'b0;
            vld_p2  <= 1'b0;
        end else begin
            mode_p1 <= (i_mode > 3'd4) ? MODE_CTRL : mode_e'(i_mode);
            vld_p1  <= 1'b1;
            vld_p2  <= vld_p1;
        end
    end

    assign o_valid = vld_p2;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
        localparam logic [9:0] VGB_SYM  = (k % 2 == 0) ? 10'b1011001100 : 10'b0100110011;
        localparam bit         IS_LANE0 = (k == 0);

        logic [8:0]              qm_p1;
        logic [1:0]              ctrl_p1;
        logic [3:0]              aux_p1;
        logic [9:0]              enc_p2;
        logic signed [CNT_W-1:0] cnt_p2;

        logic [3:0]              n1;
        logic [3:0]              n0;
        logic signed [CNT_W-1:0] diff;
        logic [9:0]              sym_nxt;
        logic signed [CNT_W-1:0] cnt_nxt;

        // Stage 1: transition minimisation and side-channel capture
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                qm_p1   <= '0;
                ctrl_p1 <= '0;
                aux_p1  <= '0;
            end else begin
                qm_p1   <= qm_encode(i_data[8*k +: 8]);
                ctrl_p1 <= i_ctrl[2*k +: 2];
                aux_p1  <= i_aux[4*k +: 4];
            end
        end

        // Any non-video symbol zeroes the running disparity.
        always_comb begin
            n1      = popcount8(qm_p1[7:0]);
            n0      = 4'd8 - n1;
            diff    = to_signed(n1) - to_signed(n0);
            sym_nxt = CTRL_SYM_00;
            cnt_nxt = ZERO;
            case (mode_p1)
                MODE_VIDEO: begin
                    if ((cnt_p2 == ZERO) || (n1 == n0)) begin
                        sym_nxt = {~qm_p1[8], qm_p1[8], qm_p1[8] ? qm_p1[7:0] : ~qm_p1[7:0]};
                        cnt_nxt = qm_p1[8] ? (cnt_p2 + diff) : (cnt_p2 - diff);
                    end else if (((cnt_p2 > ZERO) && (n1 > n0)) || ((cnt_p2 < ZERO) && (n0 > n1))) begin
                        sym_nxt = {1'b1, qm_p1[8], ~qm_p1[7:0]};
                        cnt_nxt = cnt_p2 + (qm_p1[8] ? TWO : ZERO) - diff;
                    end else begin
                        sym_nxt = {1'b0, qm_p1[8], qm_p1[7:0]};
                        cnt_nxt = cnt_p2 - (qm_p1[8] ? ZERO : TWO) + diff;
                    end
                end
                MODE_VGB:   sym_nxt = VGB_SYM;
                MODE_TERC4: sym_nxt = terc4_sym(aux_p1);
                MODE_DIGB:  sym_nxt = IS_LANE0 ? terc4_sym({2'b11, ctrl_p1}) : 10'b0100110011;
                default:    sym_nxt = ctrl_sym(ctrl_p1);
            endcase
        end

        // Stage 2: balanced / looked-up symbol and disparity state
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                enc_p2 <= CTRL_SYM_00;
                cnt_p2 <= ZERO;
            end else begin
                enc_p2 <= sym_nxt;
                cnt_p2 <= cnt_nxt;
            end
        end

        assign o_encoded[10*k +: 10] = enc_p2;

`ifdef TMDS_DISP_MON_EN
        logic err_p2;

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                err_p2 <= 1'b0;
            end else if ((cnt_nxt > POS_LIM) || (cnt_nxt < NEG_LIM)) begin
                err_p2 <= 1'b1;
            end
        end

        assign o_disp_err[k]             = err_p2;
        assign o_disp[CNT_W*k +: CNT_W]  = cnt_p2;
`endif
    end

endmodule
